ls_axim_bridge: RTL and testbench

- Sits directly downstream of the load/store unit's AXI-master request port.
- Converts each single LSU request (address, write data, byte-enables, read strobe; held until ready) into one AXI4-Lite transaction.
- Pulses ready back to the LSU with read data when the transaction completes.
- Carries exactly one outstanding transaction; no reordering.

---
 rtl/ls_axim_bridge.sv | 154 +++++++++++++++
 tb/tb_ls_axim_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_axim_bridge.sv
// LSU request port to AXI4-Lite master bridge.
// One outstanding transaction; completion returned as a one-cycle ready pulse.
module ls_axim_bridge #(
    parameter logic [2:0]  PROT     = 3'b000,
    parameter logic [31:0] ERR_RDAT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ls4axim_val,
    output logic        hs_axim4ls_rdy,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    input  logic [3:0]  i_wen,
    input  logic        i_ren,
    output logic [31:0] o_rdat,
    output logic        o_err,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_awaddr,
    output logic [2:0]  o_awprot,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_bvalid,
    output logic        o_bready,
    input  logic [1:0]  i_bresp,
    output logic        o_arvalid,
    input  logic        i_arready,
    output logic [31:0] o_araddr,
    output logic [2:0]  o_arprot,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;

    assign aw_hs = o_awvalid & i_awready;
    assign w_hs  = o_wvalid & i_wready;

    // Payload comes only from the copies latched at acceptance.
    assign o_awaddr = adr;
    assign o_araddr = adr;
    assign o_wdata  = wdat;
    assign o_wstrb  = wen;
    assign o_awprot = PROT;
    assign o_arprot = PROT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            adr            <= '0;
            wdat           <= '0;
            wen            <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            o_awvalid      <= 1'b0;
            o_wvalid       <= 1'b0;
            o_bready       <= 1'b0;
            o_arvalid      <= 1'b0;
            o_rready       <= 1'b0;
            hs_axim4ls_rdy <= 1'b0;
            o_rdat         <= '0;
            o_err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_ls4axim_val) begin
                        adr     <= i_adr;
                        wdat    <= i_wdat;
                        wen     <= i_wen;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        // A write takes priority when both strobes are present.
                        if (i_wen != 4'b0000) begin
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state     <= WADDR;
                        end else if (i_ren) begin
                            o_arvalid <= 1'b1;
                            state     <= RADDR;
                        end else begin
                            o_rdat         <= '0;
                            o_err          <= 1'b0;
                            hs_axim4ls_rdy <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                WADDR: begin
                    if (aw_hs) begin
                        o_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        o_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        o_bready <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (i_bvalid) begin
                        o_bready       <= 1'b0;
                        o_err          <= (i_bresp != 2'b00);
                        hs_axim4ls_rdy <= 1'b1;
                        state          <= DONE;
                    end
                end
                RADDR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= RDATA;
                    end
                end
                RDATA: begin
                    if (i_rvalid) begin
                        o_rready <= 1'b0;
                        if (i_rresp == 2'b00) begin
                            o_rdat <= i_rdata;
                            o_err  <= 1'b0;
                        end else begin
                            o_rdat <= ERR_RDAT;
                            o_err  <= 1'b1;
                        end
                        hs_axim4ls_rdy <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    // Request valid is deliberately ignored here.
                    hs_axim4ls_rdy <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ls_axim_bridge.sv
// Directed bench for ls_axim_bridge with a delay-configurable AXI4-Lite slave.
module tb_ls_axim_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        val = 1'b0;
    logic        rdy;
    logic [31:0] adr = '0, wdat = '0, rdat;
    logic [3:0]  wen = '0;
    logic        ren = 1'b0, err;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic        rvalid = 1'b0, rready;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    ls_axim_bridge dut (
        .clk(clk), .rst(rst),
        .hs_ls4axim_val(val), .hs_axim4ls_rdy(rdy),
        .i_adr(adr), .i_wdat(wdat), .i_wen(wen), .i_ren(ren),
        .o_rdat(rdat), .o_err(err),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awprot(awprot),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
        .i_bvalid(bvalid), .o_bready(bready), .i_bresp(bresp),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arprot(arprot),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave configuration and observation counters
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_beats = 0, w_beats = 0, ar_beats = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, viol = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic        p_aw = 0, p_awhs = 0, p_w = 0, p_whs = 0, p_ar = 0, p_arhs = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    // Slave drives ready/response at negedge for the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            p_aw = 0; p_w = 0; p_ar = 0;
        end else begin
            if (p_aw && !p_awhs && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_w && !p_whs && (!wvalid || wdata !== p_wdata)) viol++;
            if (p_ar && !p_arhs && (!arvalid || araddr !== p_araddr)) viol++;
            awready = awvalid && (aw_cnt >= aw_dly);
            wready  = wvalid && (w_cnt >= w_dly);
            arready = arvalid && (ar_cnt >= ar_dly);
            if (awvalid) begin
                aw_hi++;
                if (awready) begin aw_beats++; last_awaddr = awaddr; aw_cnt = 0; end
                else aw_cnt++;
            end
            if (wvalid) begin
                w_hi++;
                if (wready) begin w_beats++; last_wdata = wdata; last_wstrb = wstrb; w_cnt = 0; end
                else w_cnt++;
            end
            if (arvalid) begin
                ar_hi++;
                if (arready) begin ar_beats++; last_araddr = araddr; ar_cnt = 0; end
                else ar_cnt++;
            end
            bvalid = bready && (b_cnt >= b_dly);
            bresp  = bresp_cfg;
            if (bready) begin if (bvalid) b_cnt = 0; else b_cnt++; end
            rvalid = rready && (r_cnt >= r_dly);
            rresp  = rresp_cfg;
            rdata  = rdata_cfg;
            if (rready) begin if (rvalid) r_cnt = 0; else r_cnt++; end
            p_aw = awvalid; p_awhs = awready; p_awaddr = awaddr;
            p_w  = wvalid;  p_whs  = wready;  p_wdata  = wdata;
            p_ar = arvalid; p_arhs = arready; p_araddr = araddr;
        end
    end

    // Drive one request; lat counts negedges from drive to the rdy cycle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                          input logic re, input logic scr,
                          output int lat, output logic [31:0] rd, output logic er);
        logic seen;
        @(negedge clk);
        adr = a; wdat = d; wen = we; ren = re; val = 1'b1;
        lat = 0; seen = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (scr && i == 0) begin adr = ~a; wdat = ~d; wen = ~we; ren = ~re; end
            if (rdy) begin rd = rdat; er = err; seen = 1'b1; break; end
        end
        val = 1'b0;
        chk("rdy_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("rdy_pulse", {31'd0, rdy}, 32'd0);
    endtask

    int lat;
    logic [31:0] rd;
    logic er;
    int b_aw, b_w, b_ar, h_aw, h_w, h_ar;

    task automatic snap();
        b_aw = aw_beats; b_w = w_beats; b_ar = ar_beats;
        h_aw = aw_hi; h_w = w_hi; h_ar = ar_hi;
    endtask

    initial begin
        #1;
        chk("rst_outs", {26'd0, awvalid, wvalid, arvalid, bready, rready, rdy}, 32'd0);
        chk("rst_rdat", rdat, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", awaddr, 32'd0);
        #20 rst = 1'b0;

        // Zero-wait write, request inputs scrambled after acceptance
        snap();
        do_req(32'h1000_0004, 32'hA5A5_5A5A, 4'b0011, 1'b0, 1'b1, lat, rd, er);
        chk("w1_lat", lat, 32'd3);
        chk("w1_err", {31'd0, er}, 32'd0);
        chk("w1_awaddr", last_awaddr, 32'h1000_0004);
        chk("w1_wdata", last_wdata, 32'hA5A5_5A5A);
        chk("w1_wstrb", {28'd0, last_wstrb}, 32'h3);
        chk("w1_beats", (aw_beats - b_aw) * 16 + (w_beats - b_w), 32'h11);
        chk("w1_hi", (aw_hi - h_aw) * 16 + (w_hi - h_w), 32'h11);

        // Read with delayed AR ready and delayed R
        ar_dly = 3; r_dly = 2; rdata_cfg = 32'hDEAD_BEEF;
        snap();
        do_req(32'h2000_0010, 32'h0, 4'b0000, 1'b1, 1'b0, lat, rd, er);
        chk("r1_lat", lat, 32'd8);
        chk("r1_rdat", rd, 32'hDEAD_BEEF);
        chk("r1_err", {31'd0, er}, 32'd0);
        chk("r1_araddr", last_araddr, 32'h2000_0010);
        chk("r1_arhi", ar_hi - h_ar, 32'd4);
        chk("r1_beats", ar_beats - b_ar, 32'd1);
        chk("r1_hold", rdat, 32'hDEAD_BEEF);

        // No-op request: no AXI traffic, rdat cleared
        ar_dly = 0; r_dly = 0;
        snap();
        do_req(32'h5000_0000, 32'h1111_2222, 4'b0000, 1'b0, 1'b0, lat, rd, er);
        chk("nop_lat", lat, 32'd1);
        chk("nop_rdat", rd, 32'd0);
        chk("nop_err", {31'd0, er}, 32'd0);
        chk("nop_hi", (aw_hi - h_aw) + (w_hi - h_w) + (ar_hi - h_ar), 32'd0);

        // W accepted two cycles before AW
        aw_dly = 2; w_dly = 0;
        snap();
        do_req(32'h3000_0000, 32'h1234_5678, 4'b1100, 1'b0, 1'b0, lat, rd, er);
        chk("w2_lat", lat, 32'd5);
        chk("w2_whi", w_hi - h_w, 32'd1);
        chk("w2_awhi", aw_hi - h_aw, 32'd3);
        chk("w2_beats", (aw_beats - b_aw) * 16 + (w_beats - b_w), 32'h11);
        chk("w2_wstrb", {28'd0, last_wstrb}, 32'hC);
        aw_dly = 0;

        // Read error returns ERR_RDAT, then write error
        rresp_cfg = 2'b10; rdata_cfg = 32'h5555_AAAA;
        do_req(32'h0000_0040, 32'h0, 4'b0000, 1'b1, 1'b0, lat, rd, er);
        chk("re_lat", lat, 32'd3);
        chk("re_rdat", rd, 32'h0000_0000);
        chk("re_err", {31'd0, er}, 32'd1);
        rresp_cfg = 2'b00; bresp_cfg = 2'b11;
        do_req(32'h0000_0080, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, lat, rd, er);
        chk("we_lat", lat, 32'd3);
        chk("we_err", {31'd0, er}, 32'd1);
        bresp_cfg = 2'b00;

        // Both strobes: write only
        snap();
        do_req(32'h6000_0008, 32'h0BAD_F00D, 4'b1111, 1'b1, 1'b0, lat, rd, er);
        chk("wr_lat", lat, 32'd3);
        chk("wr_err", {31'd0, er}, 32'd0);
        chk("wr_beats", (aw_beats - b_aw) * 16 + (ar_beats - b_ar), 32'h10);
        chk("wr_awaddr", last_awaddr, 32'h6000_0008);

        // Reset while waiting for the write response
        b_dly = 20;
        @(negedge clk);
        adr = 32'h7000_0000; wdat = 32'h7777_7777; wen = 4'b0001; ren = 1'b0; val = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bready) break;
        end
        chk("rs_wresp", {31'd0, bready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs_outs", {26'd0, awvalid, wvalid, arvalid, bready, rready, rdy}, 32'd0);
        chk("rs_addr", awaddr, 32'd0);
        val = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        b_dly = 0;
        snap();
        do_req(32'h7000_0100, 32'h8888_8888, 4'b0010, 1'b0, 1'b0, lat, rd, er);
        chk("rs_next_lat", lat, 32'd3);
        chk("rs_next_awaddr", last_awaddr, 32'h7000_0100);
        chk("rs_next_beats", (aw_beats - b_aw) * 16 + (w_beats - b_w), 32'h11);

        chk("prot_aw", {29'd0, awprot}, 32'd0);
        chk("prot_ar", {29'd0, arprot}, 32'd0);
        chk("protocol", viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
